digit_scanner: RTL and testbench
================================

# digit_scanner

Parametrised successor to the fixed four-digit selector in the timer display path. Time-multiplexes `NRO_DIGITOS` BCD digits onto one shared seven-segment decoder, driving an active-low common-pin select bus. Adds:
- a per-digit decimal point;
- optional leading-zero blanking;
- a programmable all-off gap between digits to suppress ghosting;
- a scan enable.

It sits between the timer's BCD counters and the BCD-to-segment decoder, advanced by the shared refresh `tick`.

## Interface
- `NRO_DIGITOS`, 4: number of scanned digits, 1..16.
- `NRO_SELECT`, 6: width of the select bus, must be ≥ `NRO_DIGITOS`. Bits `[NRO_SELECT-1:NRO_DIGITOS]` are always 1 (off).
- `BLANK_TICKS`, 0: tick periods of all-off gap after each digit slot. 0 means no gap.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `tick` input 1: single-`clk` refresh strobe; one slot or gap step per tick.
- `en` input 1: scan enable.
- `lz_blank` input 1: leading-zero blanking enable.
- `num` input `BCDnumber_t [NRO_DIGITOS-1:0]`: digit values, index 0 = least significant.
- `dp` input `[NRO_DIGITOS-1:0]`: decimal point request per digit.
- `out_digit_select` output `[NRO_SELECT-1:0]`: active-low digit select, at most one bit low.
- `out_digit_number` output `BCDnumber_t`: BCD value for the decoder.
- `out_dp` output 1: decimal point for the selected digit, active-high.
- `out_blank` output 1: high when no digit is lit.

## Operation
- Registered state:
  - `idx`: `max(1,$clog2(NRO_DIGITOS))` bits.
  - `phase` ∈ {SHOW, GAP}.
  - `gap_cnt`: `max(1,$clog2(BLANK_TICKS+1))` bits.
- Reset values: `idx`=0, `phase`=SHOW, `gap_cnt`=0.
- `en`=0: state is synchronously forced to its reset values on every `clk`, and `tick` is ignored.
- SHOW with `tick`:
  - if `BLANK_TICKS`=0: `idx` advances, staying in SHOW;
  - otherwise: go to GAP with `gap_cnt`=0.
- GAP with `tick`:
  - if `gap_cnt`=`BLANK_TICKS`-1: advance `idx` and return to SHOW;
  - otherwise: `gap_cnt`+1.
- `idx` advance is `idx`+1, wrapping from `NRO_DIGITOS`-1 to 0. `idx` never holds a value ≥ `NRO_DIGITOS`.
- Leading-zero blanking: digit i ≠ 0 is suppressed when `lz_blank`=1 and `num[j]`=0 for all j ≥ i. Digit 0 is never suppressed. A digit with `dp[i]`=1 is never suppressed.
- A suppressed digit still occupies its full SHOW slot; scan timing does not depend on data.
- Outputs are combinational from the registered state and the current `num`/`dp`/`en`/`lz_blank`:
  - `lit` = `en` & SHOW & not suppressed.
  - `out_digit_select`: all ones except bit `idx` low when `lit`.
  - `out_digit_number`: `num[idx]` when `lit`, else 0.
  - `out_dp`: `dp[idx]` & `lit`.
  - `out_blank`: ~`lit`.
- Non-BCD values (>9) pass through unchanged; the decoder owns their handling.

## Timing
- Output values during reset (`rst`=1):
  - `en`=1: `out_digit_select`=~1 (bit 0 low), `out_digit_number`=`num[0]`, `out_dp`=`dp[0]`, `out_blank`=0. Digit 0 is never suppressed.
  - `en`=0: `out_digit_select` all ones, `out_digit_number`=0, `out_dp`=0, `out_blank`=1.
- `rst` assertion clears state immediately, independent of `clk`, including mid-slot or mid-gap.
- Latency from `tick` to the change on `out_digit_select`: one `clk`, visible after the edge that samples `tick`=1.
- `num`/`dp` changes appear on the outputs within the same cycle (combinational path); there is no holding register.
- One full frame lasts `NRO_DIGITOS`×(1+`BLANK_TICKS`) tick periods.
- `tick` asserted on consecutive `clk` cycles: each cycle is one step; no steps are lost or merged.
- `en` deassertion forces the outputs off in the same cycle. On re-enable, the scan restarts at digit 0, SHOW.
- `tick` and `en` falling in the same cycle: `en` wins and the state resets.

## Test plan
- `NRO_DIGITOS`=4, `BLANK_TICKS`=0, `num`={4,3,2,1}, `en`=1, tick every 3 clk -> select cycles FE,FD,FB,F7 (6-bit: 3E,3D,3B,37) with number 1,2,3,4, then wraps to 3E/1.
- `BLANK_TICKS`=2, same data -> pattern 3E, 3F, 3F, 3D, 3F, 3F, …, one tick per step; `out_blank`=1 during every 3F step.
- `lz_blank`=1, `num`={0,0,5,0}, `dp`=0 -> digits 3 and 2 show select 3F with `out_blank`=1, digit 1 shows 5, digit 0 shows 0. Setting `dp[3]`=1 lights digit 3 with value 0 and `out_dp`=1.
- Assert `rst` asynchronously while in GAP at `idx`=2 -> outputs return to digit 0 within the same cycle, and the next tick after release steps from digit 0.
- Drop `en` mid-frame while tick is high in the same cycle -> select all ones at once; on `en`=1 the scan restarts at digit 0, SHOW.
- `NRO_DIGITOS`=6, `NRO_SELECT`=8 -> six slots, select bits 7:6 stay 1, and the scan wraps from `idx` 5 to 0.

Source files
------------

// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexes BCD digits onto one seven-segment decoder
// with decimal points, leading-zero blanking, inter-digit gap and scan enable.

package digit_scanner_pkg;
    typedef logic [3:0] BCDnumber_t;
endpackage

module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int NRO_DIGITOS = 4,
    parameter int NRO_SELECT  = 6,
    parameter int BLANK_TICKS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          en,
    input  logic                          lz_blank,
    input  BCDnumber_t [NRO_DIGITOS-1:0]  num,
    input  logic       [NRO_DIGITOS-1:0]  dp,
    output logic       [NRO_SELECT-1:0]   out_digit_select,
    output BCDnumber_t                    out_digit_number,
    output logic                          out_dp,
    output logic                          out_blank
);

    localparam int IW = (NRO_DIGITOS > 1) ? $clog2(NRO_DIGITOS) : 1;
    localparam int GC = $clog2(BLANK_TICKS + 1);
    localparam int GW = (GC > 1) ? GC : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NRO_DIGITOS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(BLANK_TICKS - 1);

    typedef enum logic {
        SHOW,
        GAP
    } phase_t;

    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nxt;
    phase_t                 phase;
    logic [GW-1:0]          gap_cnt;
    logic [NRO_DIGITOS:0]   zero_from;
    logic [NRO_DIGITOS-1:0] supp;
    logic                   lit;

    assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Scan sequencer: one slot or gap step per tick, held at digit 0 while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            phase   <= SHOW;
            gap_cnt <= '0;
        end else if (!en) begin
            idx     <= '0;
            phase   <= SHOW;
            gap_cnt <= '0;
        end else if (tick) begin
            if (phase == SHOW) begin
                if (BLANK_TICKS == 0) begin
                    idx <= idx_nxt;
                end else begin
                    phase   <= GAP;
                    gap_cnt <= '0;
                end
            end else if (gap_cnt == GAP_LAST) begin
                idx   <= idx_nxt;
                phase <= SHOW;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        zero_from              = '0;
        zero_from[NRO_DIGITOS] = 1'b1;
        supp                   = '0;
        for (int i = NRO_DIGITOS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (num[i] == 4'd0);
        end
        for (int i = 1; i < NRO_DIGITOS; i++) begin
            supp[i] = lz_blank & zero_from[i] & ~dp[i];
        end
    end

    // Outputs follow the current data directly; only the scan position is stored.
    always_comb begin
        lit              = en & (phase == SHOW) & ~supp[idx];
        out_digit_select = '1;
        out_digit_number = 4'd0;
        out_dp           = 1'b0;
        out_blank        = ~lit;
        if (lit) begin
            out_digit_select[idx] = 1'b0;
            out_digit_number      = num[idx];
            out_dp                = dp[idx];
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: step-count reference model plus directed vectors
// for three configurations of digit_scanner.

module tb_digit_scanner;
    import digit_scanner_pkg::*;

    logic clk = 1'b0;
    logic rst, tick, en, lz;
    BCDnumber_t [3:0] num4;
    logic       [3:0] dp4;
    BCDnumber_t [5:0] num6;
    logic       [5:0] dp6;

    logic [5:0] sel_a, sel_b;
    logic [7:0] sel_c;
    BCDnumber_t nm_a, nm_b, nm_c;
    logic dp_a, dp_b, dp_c, bk_a, bk_b, bk_c;

    int passed = 0;
    int total  = 0;
    int st_a = 0, st_b = 0, st_c = 0;

    always #5 clk = ~clk;

    digit_scanner #(.NRO_DIGITOS(4), .NRO_SELECT(6), .BLANK_TICKS(0)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .lz_blank(lz),
        .num(num4), .dp(dp4), .out_digit_select(sel_a),
        .out_digit_number(nm_a), .out_dp(dp_a), .out_blank(bk_a));

    digit_scanner #(.NRO_DIGITOS(4), .NRO_SELECT(6), .BLANK_TICKS(2)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .lz_blank(lz),
        .num(num4), .dp(dp4), .out_digit_select(sel_b),
        .out_digit_number(nm_b), .out_dp(dp_b), .out_blank(bk_b));

    digit_scanner #(.NRO_DIGITOS(6), .NRO_SELECT(8), .BLANK_TICKS(0)) u_c (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .lz_blank(lz),
        .num(num6), .dp(dp6), .out_digit_select(sel_c),
        .out_digit_number(nm_c), .out_dp(dp_c), .out_blank(bk_c));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        else
            passed++;
    endtask

    // Reference: count steps since reset/enable; position in frame follows by division.
    always @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            st_a <= 0; st_b <= 0; st_c <= 0;
        end else if (tick) begin
            st_a <= st_a + 1; st_b <= st_b + 1; st_c <= st_c + 1;
        end
    end

    task automatic cmp_all(input string tg, input int n, input int b,
                           input int sw, input int st,
                           input logic [63:0] nv, input logic [15:0] dv,
                           input logic [31:0] asel, input logic [3:0] anum,
                           input logic adp, input logic abk);
        int slot, d;
        bit show, sup, lit;
        logic [31:0] esel;
        slot = st % (n * (1 + b));
        d    = slot / (1 + b);
        show = (slot % (1 + b)) == 0;
        sup  = 1'b0;
        if (lz && d != 0 && !dv[d]) begin
            sup = 1'b1;
            for (int j = d; j < n; j++)
                if (nv[j*4 +: 4] != 4'd0) sup = 1'b0;
        end
        lit  = en && show && !sup;
        esel = (32'h1 << sw) - 1;
        if (lit) esel[d] = 1'b0;
        chk({tg, "_sel"}, asel, esel);
        chk({tg, "_num"}, 32'(anum), lit ? 32'(nv[d*4 +: 4]) : 32'd0);
        chk({tg, "_dp"}, 32'(adp), 32'(lit && dv[d]));
        chk({tg, "_blank"}, 32'(abk), 32'(!lit));
    endtask

    always @(negedge clk) begin
        cmp_all("a", 4, 0, 6, st_a, 64'(num4), 16'(dp4),
                32'(sel_a), nm_a, dp_a, bk_a);
        cmp_all("b", 4, 2, 6, st_b, 64'(num4), 16'(dp4),
                32'(sel_b), nm_b, dp_b, bk_b);
        cmp_all("c", 6, 0, 8, st_c, 64'(num6), 16'(dp6),
                32'(sel_c), nm_c, dp_c, bk_c);
    end

    task automatic tk;
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        #1;
    endtask

    localparam logic [5:0] E_A [6] = '{6'h3D, 6'h3B, 6'h37, 6'h3E, 6'h3D, 6'h3B};
    localparam logic [3:0] N_A [6] = '{4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3};
    localparam logic [5:0] E_B [6] = '{6'h3F, 6'h3F, 6'h3D, 6'h3F, 6'h3F, 6'h3B};
    localparam logic [7:0] E_C [6] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE};
    localparam logic [3:0] N_C [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1};

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        en   = 1'b1;
        lz   = 1'b0;
        num4 = {4'd4, 4'd3, 4'd2, 4'd1};
        dp4  = '0;
        num6 = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        dp6  = '0;
        #2;
        chk("rst_en_sel", 32'(sel_a), 32'h3E);
        chk("rst_en_num", 32'(nm_a), 32'd1);
        chk("rst_en_blank", 32'(bk_a), 32'd0);
        chk("rst_en_sel_c", 32'(sel_c), 32'hFE);
        en = 1'b0;
        #1;
        chk("rst_dis_sel", 32'(sel_a), 32'h3F);
        chk("rst_dis_num", 32'(nm_a), 32'd0);
        chk("rst_dis_blank", 32'(bk_a), 32'd1);
        en = 1'b1;
        #10 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            tk();
            chk("scan_a_sel", 32'(sel_a), 32'(E_A[i]));
            chk("scan_a_num", 32'(nm_a), 32'(N_A[i]));
            chk("scan_b_sel", 32'(sel_b), 32'(E_B[i]));
            chk("scan_b_blank", 32'(bk_b), 32'(E_B[i] == 6'h3F));
            chk("scan_c_sel", 32'(sel_c), 32'(E_C[i]));
            chk("scan_c_num", 32'(nm_c), 32'(N_C[i]));
            @(posedge clk);
        end

        @(posedge clk);
        #1 tick = 1'b1;
        repeat (3) @(posedge clk);
        #1 tick = 1'b0;
        chk("burst_a_sel", 32'(sel_a), 32'h3D);
        chk("burst_b_sel", 32'(sel_b), 32'h37);
        chk("burst_c_sel", 32'(sel_c), 32'hF7);

        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        lz   = 1'b1;
        num4 = {4'd0, 4'd0, 4'd5, 4'd0};
        #1;
        chk("lz_d0_sel", 32'(sel_a), 32'h3E);
        chk("lz_d0_num", 32'(nm_a), 32'd0);
        tk();
        chk("lz_d1_sel", 32'(sel_a), 32'h3D);
        chk("lz_d1_num", 32'(nm_a), 32'd5);
        tk();
        chk("lz_d2_sel", 32'(sel_a), 32'h3F);
        chk("lz_d2_blank", 32'(bk_a), 32'd1);
        tk();
        chk("lz_d3_sel", 32'(sel_a), 32'h3F);
        dp4[3] = 1'b1;
        #1;
        chk("lz_dp_sel", 32'(sel_a), 32'h37);
        chk("lz_dp_num", 32'(nm_a), 32'd0);
        chk("lz_dp_dp", 32'(dp_a), 32'd1);
        dp4  = '0;
        lz   = 1'b0;
        num4 = {4'd4, 4'd3, 4'd2, 4'd1};

        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        repeat (7) tk();
        chk("gap_b_sel", 32'(sel_b), 32'h3F);
        chk("gap_b_blank", 32'(bk_b), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_b_sel", 32'(sel_b), 32'h3E);
        chk("arst_b_num", 32'(nm_b), 32'd1);
        chk("arst_a_sel", 32'(sel_a), 32'h3E);
        @(posedge clk);
        #1 rst = 1'b0;
        tk();
        chk("post_rst_a", 32'(sel_a), 32'h3D);
        chk("post_rst_a_num", 32'(nm_a), 32'd2);
        chk("post_rst_b", 32'(sel_b), 32'h3F);
        tk();
        tk();
        chk("post_rst_b2", 32'(sel_b), 32'h3D);

        @(posedge clk);
        #1 tick = 1'b1;
        en = 1'b0;
        #1;
        chk("endrop_sel", 32'(sel_a), 32'h3F);
        chk("endrop_blank", 32'(bk_a), 32'd1);
        @(posedge clk);
        #1 tick = 1'b0;
        chk("endrop_hold", 32'(sel_a), 32'h3F);
        en = 1'b1;
        #1;
        chk("reen_a_sel", 32'(sel_a), 32'h3E);
        chk("reen_a_num", 32'(nm_a), 32'd1);
        chk("reen_b_sel", 32'(sel_b), 32'h3E);
        tk();
        chk("reen_step", 32'(sel_a), 32'h3D);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
